// File: rtl/sum_accumulator.sv
// Block accumulator: sums BLOCK_LEN unsigned samples over valid/ready, then holds the total.
// Define SUM_ACC_SATURATE_EN to clamp the total at all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned BLOCK_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {
        StAccum = 1'b0,
        StHold  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;
    logic             carry;

    // One extra bit captures the carry-out of the ACC_W-bit add.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_sum};
    assign carry   = sum_ext[ACC_W];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StHold);

        if (clear) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (in_valid) begin
`ifdef SUM_ACC_SATURATE_EN
                        acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                        acc_d = sum_ext[ACC_W-1:0];
`endif
                        cnt_d = cnt_q + 1'b1;
                        ovf_d = ovf_q | carry;
                        if (cnt_q == LAST_CNT) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d = StAccum;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_acc = acc_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: a 12-bit and a 6-bit instance share one stimulus stream.
// Expected block totals come from plain integer sums of the accepted samples.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sum = '0;
    logic        out_ready = 1'b0;
    logic        rdy_a, rdy_b, vld_a, vld_b, ovf_a, ovf_b;
    logic [11:0] acc_a;
    logic [5:0]  acc_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned a12;
        int unsigned o12;
        int unsigned a6;
        int unsigned o6;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned m_total = 0;
    int unsigned m_cnt   = 0;
    bit          m_hold  = 1'b0;

    sum_accumulator #(.DATA_W(4), .ACC_W(12), .BLOCK_LEN(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_sum(in_sum), .out_valid(vld_a), .out_ready(out_ready), .out_acc(acc_a),
        .out_ovf(ovf_a)
    );

    sum_accumulator #(.DATA_W(4), .ACC_W(6), .BLOCK_LEN(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_sum(in_sum), .out_valid(vld_b), .out_ready(out_ready), .out_acc(acc_b),
        .out_ovf(ovf_b)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
        m_hold  = 1'b0;
        sb_q.delete();
    endtask

    // Reference model: a block is just the integer sum of BLOCK_LEN accepted samples.
    initial forever begin
        @(posedge clk);
        if (!rst_n || clear) begin
            model_reset();
        end else if (!m_hold && in_valid) begin
            exp_t e;
            m_total += int'(in_sum);
            m_cnt++;
            if (m_cnt == 8) begin
                e.a12 = m_total % 4096;
                e.o12 = (m_total >= 4096) ? 1 : 0;
`ifdef SUM_ACC_SATURATE_EN
                e.a6  = (m_total >= 64) ? 63 : m_total;
`else
                e.a6  = m_total % 64;
`endif
                e.o6  = (m_total >= 64) ? 1 : 0;
                sb_q.push_back(e);
                m_hold = 1'b1;
            end
        end else if (m_hold && out_ready) begin
            m_total = 0;
            m_cnt   = 0;
            m_hold  = 1'b0;
        end
    end

    // Monitor: compare handshake state every cycle and the held result while valid.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready_a", rdy_a, !m_hold);
            chk("in_ready_b", rdy_b, !m_hold);
            chk("out_valid_a", vld_a, m_hold);
            chk("out_valid_b", vld_b, m_hold);
            if (vld_a || vld_b) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("out_acc_a", acc_a, sb_q[0].a12);
                    chk("out_ovf_a", ovf_a, sb_q[0].o12);
                    chk("out_acc_b", acc_b, sb_q[0].a6);
                    chk("out_ovf_b", ovf_b, sb_q[0].o6);
                    if (out_ready && !clear) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [3:0] s, input bit r, input bit c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sum    = s;
        out_ready = r;
        clear     = c;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy_a"}, rdy_a, 1);
        chk({tag, "_vld_a"}, vld_a, 0);
        chk({tag, "_acc_a"}, acc_a, 0);
        chk({tag, "_ovf_a"}, ovf_a, 0);
        chk({tag, "_vld_b"}, vld_b, 0);
        chk({tag, "_acc_b"}, acc_b, 0);
    endtask

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full-scale block, downstream always ready.
        repeat (12) cyc(1, 4'hF, 1, 0);
        cyc(0, 0, 1, 0);

        // Backpressure with ignored in_valid pulses during HOLD.
        repeat (8) cyc(1, 4'd2, 0, 0);
        for (int i = 0; i < 5; i++) cyc(i[0], 4'd7, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (8) cyc(1, 4'd1, 1, 0);
        cyc(0, 0, 1, 0);

        // Gapped input 1..8.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 4'(i), 1, 0);
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 1, 0);

        // Clear mid-block and clear while holding with out_ready high.
        repeat (3) cyc(1, 4'd3, 1, 0);
        cyc(0, 0, 1, 1);
        repeat (8) cyc(1, 4'd1, 0, 0);
        cyc(0, 0, 1, 1);
        repeat (8) cyc(1, 4'd1, 1, 0);
        cyc(0, 0, 1, 0);

        // Asynchronous reset between edges, mid-block.
        repeat (4) cyc(1, 4'd9, 1, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_outputs("async_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) cyc(1, 4'd5, 1, 0);
        cyc(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 31) == 0);
        end

        // Drain: bounded wait for every expected result to be delivered.
        repeat (20) cyc(0, 0, 1, 0);
        chk("drain_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
